// File: rtl/wb_shared_arbiter_if.sv
// Classic Wishbone link: master-facing (slv) and slave-facing (mst) views of one bus.
interface wb_shared_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [DW/8-1:0]   sel;
  logic [AW-1:0]     adr;
  logic [DW-1:0]     wdat;
  logic [DW-1:0]     rdat;
  logic              ack;
  logic              err;

  // mst: the side that initiates cycles; the downstream slave carries no err.
  modport mst (
    output cyc, stb, we, sel, adr, wdat,
    input  ack, rdat
  );

  modport slv (
    input  cyc, stb, we, sel, adr, wdat,
    output ack, err, rdat
  );
endinterface

// File: rtl/wb_shared_arbiter.sv
// Two-master round-robin Wishbone arbiter; 1-cycle arbitration latency, grant held for the whole cyc.
// Optional hung-cycle watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_shared_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_shared_arbiter_if.slv      m0,
  wb_shared_arbiter_if.slv      m1,
  wb_shared_arbiter_if.mst      s,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   kill;
  logic   to_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0.cyc && m1.cyc) begin
          if (last_q) begin
            state_d = ST_G0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_G1;
            last_d  = 1'b1;
          end
        end else if (m0.cyc) begin
          state_d = ST_G0;
          last_d  = 1'b0;
        end else if (m1.cyc) begin
          state_d = ST_G1;
          last_d  = 1'b1;
        end
      end
      ST_G0: begin
        if (!m0.cyc) state_d = ST_IDLE;
      end
      ST_G1: begin
        if (!m1.cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = 2'b00;
    s.cyc  = 1'b0;
    s.stb  = 1'b0;
    s.we   = 1'b0;
    s.sel  = '0;
    s.adr  = '0;
    s.wdat = '0;
    m0.ack  = 1'b0;
    m0.rdat = '0;
    m1.ack  = 1'b0;
    m1.rdat = '0;
    case (state_q)
      ST_G0: begin
        gnt_o   = 2'b01;
        s.cyc   = m0.cyc & ~kill;
        s.stb   = m0.stb & ~kill;
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.wdat  = m0.wdat;
        m0.ack  = s.ack & m0.stb & ~kill;
        m0.rdat = s.rdat;
      end
      ST_G1: begin
        gnt_o   = 2'b10;
        s.cyc   = m1.cyc & ~kill;
        s.stb   = m1.stb & ~kill;
        s.we    = m1.we;
        s.sel   = m1.sel;
        s.adr   = m1.adr;
        s.wdat  = m1.wdat;
        m1.ack  = s.ack & m1.stb & ~kill;
        m1.rdat = s.rdat;
      end
      default: ;
    endcase
  end

  assign m0.err = to_err & (state_q == ST_G0);
  assign m1.err = to_err & (state_q == ST_G1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;

  // err fires in the TO_CYC-th stalled cycle; a coincident ack takes priority.
  always_comb begin
    cnt_d  = (s.stb && !s.ack) ? cnt_q + 16'd1 : 16'd0;
    to_err = s.stb && !s.ack && (cnt_q == TO_LIM);
    kill_d = (state_d != ST_IDLE) && (kill_q || to_err);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q  <= 16'd0;
      kill_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kill_q <= kill_d;
    end
  end

  assign kill = kill_q;
`else
  logic unused_to_cyc;

  assign to_err        = 1'b0;
  assign kill          = 1'b0;
  assign unused_to_cyc = (TO_CYC == 0);
`endif

endmodule
